voice_allocator: RTL
====================

# voice_allocator

Polyphonic voice allocator that sits between the debounced key inputs and the bank of oscillator voices. It shares `NUM_VOICES` oscillators among `NUM_KEYS` keys. It scans the keys one per enabled cycle and detects presses and releases. On each assignment it records the note and the current waveform selection for the chosen voice. When every voice is busy it applies least-recently-assigned stealing, or drops the press.

## Interface
- `NUM_VOICES`, default 4: oscillator voices managed; ≥2.
- `NUM_KEYS`, default 16: key inputs; power of two.
- `NOTE_W`, default `$clog2(NUM_KEYS)`: note index width.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ena`  in  1  scan-step enable; when low, all state holds.
- `keys`  in  `NUM_KEYS`  key levels, already debounced/synchronised; 1 = held.
- `waveform_in`  in  2  current waveform code (00 square, 01 triangle, 10 sawtooth), sampled at assignment.
- `voice_active`  out  `NUM_VOICES`  voice v owns a note.
- `voice_note`  out  `NUM_VOICES*NOTE_W`  packed note index per voice; v at `[v*NOTE_W +: NOTE_W]`.
- `voice_wave`  out  `NUM_VOICES*2`  packed waveform latched per voice.
- `voice_trig`  out  `NUM_VOICES`  one-cycle pulse on (re)assignment of voice v.
- `overflow`  out  1  one-cycle pulse when a press found no free voice.

## Operation
- Registers: scan pointer `ptr` (`NOTE_W` bits), `prev[NUM_KEYS]` (last-seen key levels), per-voice `active`, `note`, `wave`, and `age` (`$clog2(NUM_VOICES)` bits, LRU rank).
- Reset clears every register and every output to 0.
- Each cycle with `ena`=1, key k=`ptr` is evaluated, `prev[k]` ← `keys[k]`, and `ptr` ← `ptr+1`, wrapping from `NUM_KEYS-1` to 0. With `ena`=0, nothing changes and pulses are 0.
- Press (`keys[k]`=1, `prev[k]`=0):
  - If any voice is free, pick the lowest-index free voice v. Increment `age` of every active voice. Set v active with `note`=k, `wave`=`waveform_in`, `age`=0. Pulse `voice_trig[v]`.
  - If all voices are busy, the overflow handling under Configuration applies, and `overflow` pulses.
- Release (`keys[k]`=0, `prev[k]`=1):
  - If an active voice v holds note k, clear `active[v]` and decrement `age` of every active voice whose age exceeds `age[v]`.
  - If no active voice holds k (for example, it was stolen), the release is a no-op.
- No change (`keys[k]` equals `prev[k]`): only `ptr` advances.
- Invariant: active ages are a permutation of 0..(count−1); age 0 is the newest assignment.
- Inactive voices keep their last `note` and `wave`.

## Timing
- The decision for key k, made in an `ena` cycle at edge t, is visible on all outputs after that edge. All outputs are registered.
- Worst-case detection latency is `NUM_KEYS` enabled cycles from a key change.
- `voice_trig` and `overflow` are high for exactly one clock.
- At most one event is processed per enabled cycle, so simultaneous key changes are serviced in scan order.
- Asserting `rst` mid-scan clears everything on the next edge. A key still held after reset is seen as a fresh press when scanned.
- Changing `waveform_in` affects only later assignments.

## Configuration
- `VOICE_STEAL_EN` defined: on a press with all voices busy, steal the voice with `age`=`NUM_VOICES-1`. Increment all other ages, then set that voice's `note`=k, `wave`=`waveform_in`, `age`=0, and pulse `voice_trig`. `voice_active` remains all ones.
- `VOICE_STEAL_EN` undefined: the press is dropped. Voice state is unchanged and `prev[k]` is still updated, so the press is not retried until the key is released and pressed again.
- `overflow` pulses in both builds.

## Test plan
- Reset with `keys`=0 → all outputs 0. Hold `ena`=1 for 16 cycles → outputs stay 0 and `ptr` wraps to 0.
- Press key 5 with `waveform_in`=01 → within 16 enabled cycles, voice 0 is active, note 5, wave 01, and `voice_trig`=0001 for one cycle. Release key 5 → `voice_active`=0000.
- Press keys 1, 2, 3, 4 (N=4), then key 7, with stealing enabled → voice 0 (holding key 1, oldest) gets note 7, `voice_trig`=0001, `overflow` pulses once. Releasing key 1 then causes no change.
- Same sequence without `VOICE_STEAL_EN` → voices keep notes 1, 2, 3, 4 and `overflow` pulses once. After releasing key 2 and re-pressing key 7, voice 1 gets note 7.
- Press keys 1, 2, 3; release 2; press 9 → voice 1 is reused. Ages become voice 0 = 2, voice 2 = 1, voice 1 = 0, consistent with LRU order.
- Toggle `ena` low mid-scan while keys change → no state or pulse changes while low. `rst` asserted during activity → all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans keys, assigns voices, LRU-ranks them.
// Define VOICE_STEAL_EN to steal the oldest voice when all are busy.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_KEYS   = 16,
  parameter int NOTE_W     = $clog2(NUM_KEYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [NUM_KEYS-1:0]          keys,
  input  logic [1:0]                   waveform_in,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*2-1:0]      voice_wave,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic                         overflow
);

  localparam int AGE_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  logic [NOTE_W-1:0]     ptr;
  logic [NUM_KEYS-1:0]   prev;
  logic [NUM_VOICES-1:0] active;
  logic [NOTE_W-1:0]     note [NUM_VOICES];
  logic [1:0]            wave [NUM_VOICES];
  logic [AGE_W-1:0]      age  [NUM_VOICES];

  logic                  cur;
  logic                  press;
  logic                  release_ev;
  logic                  have_free;
  logic                  have_hit;
  logic [NUM_VOICES-1:0] free_oh;
  logic [NUM_VOICES-1:0] hit_oh;
  logic [AGE_W-1:0]      hit_age;

  always_comb begin
    cur        = keys[ptr];
    press      = cur & ~prev[ptr];
    release_ev = ~cur & prev[ptr];
    free_oh    = '0;
    hit_oh     = '0;
    hit_age    = '0;
    have_free  = 1'b0;
    have_hit   = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!active[v] && !have_free) begin
        free_oh[v] = 1'b1;
        have_free  = 1'b1;
      end
      if (active[v] && note[v] == ptr && !have_hit) begin
        hit_oh[v] = 1'b1;
        hit_age   = age[v];
        have_hit  = 1'b1;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  // Ages form a permutation when all voices are busy, so exactly one matches.
  logic [NUM_VOICES-1:0] old_oh;

  always_comb begin
    old_oh = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      old_oh[v] = active[v] && (age[v] == AGE_MAX);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      prev       <= '0;
      active     <= '0;
      voice_trig <= '0;
      overflow   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note[v] <= '0;
        wave[v] <= '0;
        age[v]  <= '0;
      end
    end else begin
      voice_trig <= '0;
      overflow   <= 1'b0;
      if (ena) begin
        ptr       <= ptr + NOTE_W'(1);
        prev[ptr] <= cur;
        unique case (1'b1)
          press && have_free: begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (free_oh[v]) begin
                active[v]     <= 1'b1;
                note[v]       <= ptr;
                wave[v]       <= waveform_in;
                age[v]        <= '0;
                voice_trig[v] <= 1'b1;
              end else if (active[v]) begin
                age[v] <= age[v] + AGE_ONE;
              end
            end
          end
          press && !have_free: begin
            overflow <= 1'b1;
`ifdef VOICE_STEAL_EN
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (old_oh[v]) begin
                note[v]       <= ptr;
                wave[v]       <= waveform_in;
                age[v]        <= '0;
                voice_trig[v] <= 1'b1;
              end else begin
                age[v] <= age[v] + AGE_ONE;
              end
            end
`endif
          end
          release_ev && have_hit: begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (hit_oh[v]) begin
                active[v] <= 1'b0;
              end else if (active[v] && age[v] > hit_age) begin
                age[v] <= age[v] - AGE_ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    voice_active = active;
    voice_note   = '0;
    voice_wave   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note[v*NOTE_W +: NOTE_W] = note[v];
      voice_wave[v*2 +: 2]           = wave[v];
    end
  end

endmodule
